rom_load_ctrl: RTL and testbench
================================

RESET_FSM... 

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL provide parameter HDR_LEN, default 16, iNES header length in bytes.
REQ-002 SHALL provide parameter TRAINER_LEN, default 512, trainer bytes skipped when header byte6 bit2 set.
REQ-003 SHALL provide port clk  input  1  single clock for all state.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port start  input  1  pulse: UART receive buffer holds a complete image.
REQ-006 SHALL provide port halt  input  1  level: leave RUN and return to IDLE.
REQ-007 SHALL provide port rd_ptr  output  16  UART receive-buffer read address.
REQ-008 SHALL provide port rd_data  input  8  buffer byte, valid exactly 1 cycle after rd_ptr.
REQ-009 SHALL provide port prog  output  1  rom_master program-mode enable.
REQ-010 SHALL provide port prog_we  output  1  write strobe, one byte per asserted cycle.
REQ-011 SHALL provide port prog_sel  output  1  target: 0 = PRG space, 1 = CHR space.
REQ-012 SHALL provide port prog_addr  output  15  byte offset within the selected space.
REQ-013 SHALL provide port prog_di  output  8  byte to write.
REQ-014 SHALL provide port tx_data  output  8  status character to UART transmitter.
REQ-015 SHALL provide port tx_start  output  1  one-cycle send request.
REQ-016 SHALL provide port tx_done  input  1  transmitter finished current character.
REQ-017 SHALL provide port running  output  1  image loaded, CPU/PPU may run.
REQ-018 SHALL provide port err_code  output  3  last failure cause (0 = none).

Function
REQ-019 SHALL implement states IDLE, HDR, CHECK, COPY_PRG, COPY_CHR, REPORT, RUN.
REQ-020 SHALL move IDLE->HDR on start=1; start SHALL be ignored outside IDLE.
REQ-021 HDR SHALL read buffer bytes 0..HDR_LEN-1, one address per cycle, capturing each byte the cycle after its address.
REQ-022 CHECK (one cycle) SHALL fail with err_code: 1 if bytes0-3 != 4E 45 53 1A; 2 if byte4 not in {1,2}; 3 if byte5 not in {0,1}; 4 if byte6[7:4] or byte7[7:4] nonzero; lowest code wins.
REQ-023 On pass, source pointer SHALL start at HDR_LEN, plus TRAINER_LEN if byte6[2]=1.
REQ-024 COPY_PRG SHALL copy byte4*16384 bytes to prog_sel=0, prog_addr 0 upward; COPY_CHR SHALL copy byte5*8192 bytes to prog_sel=1; COPY_CHR skipped when byte5=0.
REQ-025 Copy SHALL be pipelined: one rd_ptr per cycle, prog_we with matching prog_addr/prog_di one cycle later, sustained 1 byte/cycle, no gap at PRG->CHR boundary.
REQ-026 prog_addr SHALL be 15-bit and never wrap: last PRG write at 0x3FFF (1 bank) or 0x7FFF (2 banks), last CHR write at 0x1FFF.
REQ-027 rd_ptr SHALL be 16-bit; a source address beyond 0xFFFF SHALL not occur for legal headers (max 16+512+32768+8192).
REQ-028 prog SHALL be 1 from entry of COPY_PRG through the last prog_we cycle, 0 otherwise.
REQ-029 REPORT SHALL pulse tx_start for one cycle on entry with tx_data=0x53 ('S') on success or 0x46 ('F') on failure, then wait for tx_done.
REQ-030 On tx_done in REPORT: success -> RUN, failure -> IDLE.
REQ-031 RUN SHALL hold running=1; halt=1 SHALL return to IDLE with running=0 next cycle.
REQ-032 err_code SHALL clear to 0 on IDLE->HDR and hold its value after failure until the next start.
REQ-033 tx_done outside REPORT SHALL be ignored.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE, rd_ptr=0, prog=0, prog_we=0, prog_sel=0, prog_addr=0, prog_di=0, tx_data=0, tx_start=0, running=0, err_code=0.
REQ-035 rst asserted mid-copy SHALL drop prog and prog_we immediately; no further writes after release until a new start.

Verification
REQ-036 Header 4E 45 53 1A 02 01 00 00..., start -> 32768 PRG writes (0x0000-0x7FFF) then 8192 CHR writes, contiguous, 'S' sent, running=1 after tx_done.
REQ-037 Header byte0=4D, start -> no prog_we, tx_data=0x46, err_code=1, IDLE after tx_done.
REQ-038 Header byte4=1, byte5=0, byte6=0x04 -> first PRG byte from buffer address 528, 16384 writes, no CHR writes.
REQ-039 Header byte6=0x10 -> err_code=4, 'F' sent, no prog_we.
REQ-040 rst pulsed during COPY_PRG at write 100 -> prog=0 same cycle, all outputs at reset values, start reloads fully.
REQ-041 In RUN, start pulse ignored; halt=1 -> running=0 and IDLE next cycle.

Source files
------------

// File: rtl/rom_load_ctrl.sv
// Loads an iNES image from the UART receive buffer into PRG/CHR program memory,
// validates the header, reports 'S'/'F' over the UART and gates CPU/PPU run.
`timescale 1ns/1ps
module rom_load_ctrl #(
    parameter int HDR_LEN     = 16,
    parameter int TRAINER_LEN = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    output logic [15:0] rd_ptr,
    input  logic [7:0]  rd_data,
    output logic        prog,
    output logic        prog_we,
    output logic        prog_sel,
    output logic [14:0] prog_addr,
    output logic [7:0]  prog_di,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        running,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE, HDR, CHECK, COPY_PRG, COPY_CHR, REPORT, RUN
    } state_t;

    localparam logic [15:0] HDR_LEN_W = 16'(HDR_LEN);
    localparam logic [15:0] TRN_LEN_W = 16'(TRAINER_LEN);

    state_t      state_q, state_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] hdr_cnt_q, hdr_cnt_d;
    logic [14:0] cnt_q, cnt_d;
    logic        prog_q, prog_d;
    logic        prog_we_q, prog_we_d;
    logic        prog_sel_q, prog_sel_d;
    logic [14:0] prog_addr_q, prog_addr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic [2:0]  err_q, err_d;
    logic        ok_q, ok_d;

    // Only the first eight header bytes carry information we act on.
    logic [63:0] hdr_bytes;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hdr
            logic [7:0] byte_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_q <= 8'h00;
                end else if (state_q == HDR && hdr_cnt_q == 16'(gi + 1)) begin
                    byte_q <= rd_data;
                end
            end
            assign hdr_bytes[gi*8 +: 8] = byte_q;
        end
    endgenerate

    logic [7:0]  b4, b5, b6, b7;
    logic [2:0]  chk_err;
    logic [15:0] src_start;
    logic [14:0] prg_last;

    assign b4 = hdr_bytes[39:32];
    assign b5 = hdr_bytes[47:40];
    assign b6 = hdr_bytes[55:48];
    assign b7 = hdr_bytes[63:56];

    always_comb begin
        chk_err = 3'd0;
        if (hdr_bytes[31:0] != 32'h1A53454E) begin
            chk_err = 3'd1;
        end else if (b4 != 8'd1 && b4 != 8'd2) begin
            chk_err = 3'd2;
        end else if (b5 > 8'd1) begin
            chk_err = 3'd3;
        end else if ((b6 & 8'hF0) != 8'h00 || (b7 & 8'hF0) != 8'h00) begin
            chk_err = 3'd4;
        end
    end

    assign src_start = HDR_LEN_W + (b6[2] ? TRN_LEN_W : 16'd0);
    assign prg_last  = b4[1] ? 15'h7FFF : 15'h3FFF;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        hdr_cnt_d   = hdr_cnt_q;
        cnt_d       = cnt_q;
        prog_we_d   = 1'b0;
        prog_sel_d  = prog_sel_q;
        prog_addr_d = prog_addr_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        err_d       = err_q;
        ok_d        = ok_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HDR;
                    rd_ptr_d  = 16'd0;
                    hdr_cnt_d = 16'd0;
                    err_d     = 3'd0;
                end
            end
            HDR: begin
                // Byte n is captured when hdr_cnt_q == n+1, one cycle after its address.
                hdr_cnt_d = hdr_cnt_q + 16'd1;
                if (hdr_cnt_q < HDR_LEN_W - 16'd1) begin
                    rd_ptr_d = rd_ptr_q + 16'd1;
                end
                if (hdr_cnt_q == HDR_LEN_W) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (chk_err != 3'd0) begin
                    err_d      = chk_err;
                    ok_d       = 1'b0;
                    state_d    = REPORT;
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h46;
                end else begin
                    ok_d     = 1'b1;
                    rd_ptr_d = src_start;
                    cnt_d    = 15'd0;
                    state_d  = COPY_PRG;
                end
            end
            COPY_PRG, COPY_CHR: begin
                // Write side lags the read address by one cycle to meet rd_data.
                prog_we_d   = 1'b1;
                prog_sel_d  = (state_q == COPY_CHR);
                prog_addr_d = cnt_q;
                rd_ptr_d    = rd_ptr_q + 16'd1;
                cnt_d       = cnt_q + 15'd1;
                if (state_q == COPY_PRG && cnt_q == prg_last) begin
                    cnt_d = 15'd0;
                    if (b5 == 8'd0) begin
                        state_d    = REPORT;
                        tx_start_d = 1'b1;
                        tx_data_d  = 8'h53;
                    end else begin
                        state_d = COPY_CHR;
                    end
                end else if (state_q == COPY_CHR && cnt_q == 15'h1FFF) begin
                    cnt_d      = 15'd0;
                    state_d    = REPORT;
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h53;
                end
            end
            REPORT: begin
                if (tx_done) begin
                    state_d = ok_q ? RUN : IDLE;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        prog_d = (state_d == COPY_PRG) || (state_d == COPY_CHR) || prog_we_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= 16'd0;
            hdr_cnt_q   <= 16'd0;
            cnt_q       <= 15'd0;
            prog_q      <= 1'b0;
            prog_we_q   <= 1'b0;
            prog_sel_q  <= 1'b0;
            prog_addr_q <= 15'd0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            err_q       <= 3'd0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            hdr_cnt_q   <= hdr_cnt_d;
            cnt_q       <= cnt_d;
            prog_q      <= prog_d;
            prog_we_q   <= prog_we_d;
            prog_sel_q  <= prog_sel_d;
            prog_addr_q <= prog_addr_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            err_q       <= err_d;
            ok_q        <= ok_d;
        end
    end

    assign rd_ptr    = rd_ptr_q;
    assign prog      = prog_q;
    assign prog_we   = prog_we_q;
    assign prog_sel  = prog_sel_q;
    assign prog_addr = prog_addr_q;
    assign prog_di   = prog_we_q ? rd_data : 8'h00;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign running   = (state_q == RUN);
    assign err_code  = err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: buffer memory model, write scoreboard, table of
// header-rejection vectors and hand sequences for loads, reset and RUN/halt.
`timescale 1ns/1ps
module tb_rom_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        tx_done = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic [15:0] rd_ptr;
    logic        prog, prog_we, prog_sel, tx_start, running;
    logic [14:0] prog_addr;
    logic [7:0]  prog_di, tx_data;
    logic [2:0]  err_code;

    rom_load_ctrl #(.HDR_LEN(16), .TRAINER_LEN(512)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .rd_ptr(rd_ptr), .rd_data(rd_data),
        .prog(prog), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_addr(prog_addr), .prog_di(prog_di),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .running(running), .err_code(err_code)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) rd_data <= mem[rd_ptr];

    int total = 0;
    int bad = 0;

    // write scoreboard, restarted whenever prog rises
    int total_wr = 0, wr_cnt = 0, prg_cnt = 0, chr_cnt = 0, bad_wr = 0;
    int tx_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    int exp_src = 16, exp_prg_len = 0;
    logic prog_prev = 1'b0;
    logic       exp_sel;
    logic [14:0] exp_addr;
    logic [7:0]  exp_di;

    always @(negedge clk) begin
        cyc++;
        if (prog && !prog_prev) begin
            wr_cnt = 0; prg_cnt = 0; chr_cnt = 0; bad_wr = 0;
            first_cyc = 0; last_cyc = 0;
        end
        prog_prev = prog;
        if (tx_start) tx_cnt++;
        if (prog_we) begin
            exp_sel  = (wr_cnt >= exp_prg_len);
            exp_addr = exp_sel ? 15'(wr_cnt - exp_prg_len) : 15'(wr_cnt);
            exp_di   = mem[16'(exp_src + wr_cnt)];
            if (!prog || prog_sel !== exp_sel || prog_addr !== exp_addr || prog_di !== exp_di)
                bad_wr++;
            if (wr_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            if (prog_sel) chr_cnt++; else prg_cnt++;
            wr_cnt++;
            total_wr++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input logic [7:0] b7);
        mem[0] = b0; mem[1] = 8'h45; mem[2] = 8'h53; mem[3] = 8'h1A;
        mem[4] = b4; mem[5] = b5; mem[6] = b6; mem[7] = b7;
        for (int i = 8; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk) tx_done = 1'b1;
        @(negedge clk) tx_done = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
    endtask

    task automatic run_load(input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6,
                            input int src);
        bit seen;
        exp_src     = src;
        exp_prg_len = int'(b4) * 16384;
        set_hdr(8'h4E, b4, b5, b6, 8'h00);
        pulse_start();
        wait_tx(50000, seen);
        check("load tx_start seen", 32'(seen), 32'd1);
        check("load tx_data", 32'(tx_data), 32'h53);
        @(negedge clk);
        check("load prog low after copy", 32'(prog), 32'd0);
        check("load prg writes", 32'(prg_cnt), 32'(int'(b4) * 16384));
        check("load chr writes", 32'(chr_cnt), 32'(int'(b5) * 8192));
        check("load write contents", 32'(bad_wr), 32'd0);
        check("load contiguous", 32'(last_cyc - first_cyc + 1), 32'(wr_cnt));
        check("load err_code", 32'(err_code), 32'd0);
        pulse_tx_done();
        check("load running", 32'(running), 32'd1);
        $display("load b4=%0d b5=%0d b6=0x%02h src=%0d: prg=%0d chr=%0d tx=0x%02h",
                 b4, b5, b6, src, prg_cnt, chr_cnt, tx_data);
    endtask

    typedef struct {
        logic [7:0] b0, b4, b5, b6, b7;
        logic [2:0] err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int base_wr, base_tx;

        vecs[0] = '{8'h4D, 8'h02, 8'h01, 8'h00, 8'h00, 3'd1};
        vecs[1] = '{8'h4E, 8'h00, 8'h01, 8'h00, 8'h00, 3'd2};
        vecs[2] = '{8'h4E, 8'h03, 8'h00, 8'h00, 8'h00, 3'd2};
        vecs[3] = '{8'h4E, 8'h01, 8'h02, 8'h00, 8'h00, 3'd3};
        vecs[4] = '{8'h4E, 8'h01, 8'h00, 8'h10, 8'h00, 3'd4};
        vecs[5] = '{8'h4E, 8'h02, 8'h01, 8'h00, 8'h20, 3'd4};
        vecs[6] = '{8'h4D, 8'h00, 8'h05, 8'hF0, 8'hF0, 3'd1};
        vecs[7] = '{8'h4E, 8'h01, 8'h07, 8'h80, 8'h00, 3'd3};

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + (i >> 8) + 3);

        // reset values
        repeat (2) @(negedge clk);
        check("reset ctrl bits", 32'({prog, prog_we, prog_sel, tx_start, running}), 32'd0);
        check("reset rd_ptr", 32'(rd_ptr), 32'd0);
        check("reset prog_addr/di", 32'({prog_addr, prog_di}), 32'd0);
        check("reset tx_data/err", 32'({tx_data, err_code}), 32'd0);
        rst = 1'b0;
        $display("reset released");

        // two PRG banks plus one CHR bank, no trainer
        run_load(8'd2, 8'd1, 8'h00, 16);

        // RUN: start ignored, tx_done ignored, halt returns to IDLE
        base_wr = total_wr; base_tx = tx_cnt;
        pulse_start();
        repeat (25) @(negedge clk);
        check("run start ignored running", 32'(running), 32'd1);
        check("run start ignored writes", 32'(total_wr - base_wr), 32'd0);
        check("run start ignored tx", 32'(tx_cnt - base_tx), 32'd0);
        @(negedge clk) halt = 1'b1;
        @(negedge clk);
        check("halt running", 32'(running), 32'd0);
        halt = 1'b0;
        pulse_tx_done();
        repeat (5) @(negedge clk);
        check("idle tx_done ignored tx", 32'(tx_cnt - base_tx), 32'd0);
        check("idle tx_done ignored running", 32'(running), 32'd0);
        $display("run/halt sequence done");

        // reset in the middle of a PRG copy
        exp_src = 16; exp_prg_len = 32768;
        set_hdr(8'h4E, 8'd2, 8'd1, 8'h00, 8'h00);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (wr_cnt == 100) seen = 1'b1;
        end
        check("midcopy reached write 100", 32'(seen), 32'd1);
        check("midcopy writes so far", 32'(bad_wr), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("midcopy prog/we dropped", 32'({prog, prog_we}), 32'd0);
        check("midcopy other ctrl", 32'({prog_sel, tx_start, running}), 32'd0);
        check("midcopy rd_ptr", 32'(rd_ptr), 32'd0);
        check("midcopy prog_addr/di", 32'({prog_addr, prog_di}), 32'd0);
        check("midcopy tx_data/err", 32'({tx_data, err_code}), 32'd0);
        @(negedge clk) rst = 1'b0;
        base_wr = total_wr; base_tx = tx_cnt;
        repeat (30) @(negedge clk);
        check("after reset no writes", 32'(total_wr - base_wr), 32'd0);
        check("after reset no tx", 32'(tx_cnt - base_tx), 32'd0);
        $display("reset during copy at write 100");

        // reload: one PRG bank, no CHR, trainer present (source starts at 528)
        run_load(8'd1, 8'd0, 8'h04, 528);

        @(negedge clk) halt = 1'b1;
        @(negedge clk) halt = 1'b0;

        // header rejection table
        for (int v = 0; v < 8; v++) begin
            set_hdr(vecs[v].b0, vecs[v].b4, vecs[v].b5, vecs[v].b6, vecs[v].b7);
            base_wr = total_wr;
            pulse_start();
            check($sformatf("vec%0d err cleared", v), 32'(err_code), 32'd0);
            wait_tx(100, seen);
            check($sformatf("vec%0d tx_start seen", v), 32'(seen), 32'd1);
            check($sformatf("vec%0d tx_data", v), 32'(tx_data), 32'h46);
            check($sformatf("vec%0d err_code", v), 32'(err_code), 32'(vecs[v].err));
            check($sformatf("vec%0d no writes", v), 32'(total_wr - base_wr), 32'd0);
            pulse_tx_done();
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d not running", v), 32'(running), 32'd0);
            check($sformatf("vec%0d err held", v), 32'(err_code), 32'(vecs[v].err));
            $display("vec%0d hdr=%02h..%02h %02h %02h %02h: tx=0x%02h err=%0d",
                     v, vecs[v].b0, vecs[v].b4, vecs[v].b5, vecs[v].b6, vecs[v].b7,
                     tx_data, err_code);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
